// File: rtl/command_decoder.sv
// Host command byte assembler for the SUMP-style analyzer: turns a UART byte
// stream into 1-byte short or 5-byte long commands, with an inter-byte timeout.
module command_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] command,
  output logic        cmd_recv_rx,
  output logic        cmd_long,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ARGS = 1'b1
  } state_t;

  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_hold_op;
  logic [23:0]           r_arg;
  logic [1:0]            r_byte_cnt;
  logic [CNT_WIDTH-1:0]  r_timer;
  logic [7:0]            r_opcode;
  logic [31:0]           r_command;
  logic                  r_cmd_recv;
  logic                  r_cmd_long;
  logic                  r_timeout_err;

  logic w_short;
  logic w_start_long;
  logic w_arg_byte;
  logic w_complete;
  logic w_expire;

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_short      = 1'b0;
    w_start_long = 1'b0;
    w_arg_byte   = 1'b0;
    w_complete   = 1'b0;
    w_expire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            w_start_long = 1'b1;
            w_next_state = S_ARGS;
          end else begin
            w_short = 1'b1;
          end
        end
      end
      S_ARGS: begin
        // An arriving byte beats an expiring timer on the same cycle.
        if (rx_valid) begin
          w_arg_byte = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_complete   = 1'b1;
            w_next_state = S_IDLE;
          end
        end else if (TIMEOUT_EN && (r_timer == TIMER_LAST)) begin
          w_expire     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_op     <= '0;
      r_arg         <= '0;
      r_byte_cnt    <= '0;
      r_timer       <= '0;
      r_opcode      <= '0;
      r_command     <= '0;
      r_cmd_recv    <= 1'b0;
      r_cmd_long    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cmd_recv    <= w_short | w_complete;
      r_timeout_err <= w_expire;

      if (w_short) begin
        r_opcode   <= rx_data;
        r_command  <= '0;
        r_cmd_long <= 1'b0;
      end else if (w_complete) begin
        r_opcode   <= r_hold_op;
        r_command  <= {rx_data, r_arg};
        r_cmd_long <= 1'b1;
      end

      if (w_start_long) begin
        r_hold_op  <= rx_data;
        r_arg      <= '0;
        r_byte_cnt <= '0;
        r_timer    <= '0;
      end else if (w_arg_byte) begin
        // The fourth byte goes straight into the output, so only three are held.
        case (r_byte_cnt)
          2'd0:    r_arg[7:0]   <= rx_data;
          2'd1:    r_arg[15:8]  <= rx_data;
          2'd2:    r_arg[23:16] <= rx_data;
          default: r_arg        <= r_arg;
        endcase
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_timer    <= '0;
      end else if ((r_state == S_ARGS) && TIMEOUT_EN && !w_expire) begin
        r_timer <= r_timer + CNT_WIDTH'(1);
      end
    end
  end

  assign opcode      = r_opcode;
  assign command     = r_command;
  assign cmd_recv_rx = r_cmd_recv;
  assign cmd_long    = r_cmd_long;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state == S_ARGS);

endmodule

// File: doc/command_decoder.md
Name: command_decoder

Overview:
- Byte-stream side of the host command interface for the SUMP-style logic analyzer.
- Consumes bytes from the UART receiver and assembles them into short commands (1 byte) or long commands (5 bytes).
- Presents each completed command as opcode, a 32-bit argument and a one-cycle strobe to the capture controller.
- Discards stalled partial long commands after a timeout so the host can resynchronise.

Parameters:
TIMEOUT_CYCLES, 100000, clock cycles allowed between consecutive bytes of a long command before it is discarded; 0 disables the timeout
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1) (minimum 1), width of the inter-byte timeout counter

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte from the UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid on this cycle
opcode  output  8  opcode of the last completed command; held until the next command completes
command  output  32  argument of the last completed command, little-endian; held until the next command completes
cmd_recv_rx  output  1  one-cycle pulse: opcode/command have just been updated
cmd_long  output  1  1 if the last completed command was long (opcode[7]=1), else 0; held
timeout_err  output  1  one-cycle pulse: a partial long command was discarded
busy  output  1  high while in ARGS state (long command partially received)

Behaviour:
- Reset values: opcode=0x00, command=0x00000000, cmd_recv_rx=0, cmd_long=0, timeout_err=0, busy=0; state=IDLE, byte_cnt=0, timer=0.
- Reset has priority over every other event. Reset mid-command discards the partial command and does not pulse cmd_recv_rx or timeout_err.
- State IDLE, on rx_valid:
  - rx_data[7]=0 (short command): next cycle opcode=rx_data, command=0, cmd_long=0, cmd_recv_rx=1. Stay in IDLE.
  - rx_data[7]=1 (long command): latch the byte into an internal opcode holding register, clear the argument shift register, byte_cnt=0, timer=0, go to ARGS. Outputs are unchanged.
- State ARGS, on rx_valid:
  - Byte k (k=0..3) is written to argument bits [8k+7:8k], so the first argument byte is the LSB. byte_cnt increments and timer clears.
  - On the 4th byte (byte_cnt==3): next cycle opcode=held opcode, command=assembled value, cmd_long=1, cmd_recv_rx=1; go to IDLE.
- Latency: cmd_recv_rx asserts exactly 1 cycle after the rx_valid cycle of the final byte. opcode, command and cmd_long update on that same cycle.
- ARGS timeout:
  - When rx_valid=0, timer increments each cycle.
  - When timer reaches TIMEOUT_CYCLES-1 without a byte: next cycle timeout_err=1 for one cycle, state=IDLE, partial data dropped, outputs unchanged.
  - If rx_valid coincides with the expiry cycle, the byte wins: it is accepted and the timer clears.
  - TIMEOUT_CYCLES=0: timer never expires.
- opcode/command are never updated without a cmd_recv_rx pulse. They are never partially updated.
- Back-to-back: a byte on the cycle immediately after a command completes is decoded normally (full throughput, one byte per cycle).
- cmd_recv_rx and timeout_err are never high on the same cycle.
- busy = (state==ARGS), registered.

Test Plan:
- Reset then rx_valid with 0x00 -> 1 cycle later cmd_recv_rx=1 for one cycle, opcode=0x00, command=0x00000000, cmd_long=0.
- Bytes 0x80,0x10,0x20,0x30,0x40 (arbitrary gaps < timeout) -> single cmd_recv_rx 1 cycle after the 0x40 byte, opcode=0x80, command=0x40302010, cmd_long=1; busy high from after 0x80 until completion.
- TIMEOUT_CYCLES=16: bytes 0xC0,0x11, then idle 20 cycles -> timeout_err pulses once, busy drops, no cmd_recv_rx; then 0x02 -> opcode=0x02, command=0.
- TIMEOUT_CYCLES=16: rx_valid exactly on the expiry cycle -> byte accepted, no timeout_err; the command completes normally with the correct value.
- Bytes 0x81,0xAA, then reset asserted for 1 cycle, then 0x01 -> no pulse from the aborted command; opcode=0x01, command=0; previously held outputs read 0 after reset.
- Consecutive-cycle stream 0x82,1,2,3,4,0x11 -> two cmd_recv_rx pulses: first opcode=0x82, command=0x04030201; second opcode=0x11, command=0.
